memory_controller: RTL and testbench
====================================

# memory_controller

Single-port arbiter between the instruction cache, the load/store buffer (LSB) and the byte-wide RAM/IO bus. It is the responder to the i_cache fetch handshake and the LSB load/store handshake. It serialises each request into 1–4 byte-sized RAM accesses, assembles read data little-endian, and returns it with a one-cycle ready pulse. It stalls IO stores while `io_buffer_full` is high.

## Interface
- `IO_BASE_HI`, default 2'b11: value of addr[17:16] that marks an IO address.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rdy`  in  1  global enable; when low, all state and outputs hold
- `mem_din`  in  8  RAM read byte, valid the cycle after the address is driven
- `mem_dout`  out  8  RAM write byte
- `mem_a`  out  32  RAM byte address
- `mem_wr`  out  1  1 = write, 0 = read
- `io_buffer_full`  in  1  IO write FIFO full
- `ic_ins_asked`  in  1  one-cycle fetch request pulse
- `ic_ins_addr`  in  32  fetch address (word aligned)
- `ic_enable`  out  1  controller can accept a fetch request
- `ic_ins_rdy`  out  1  one-cycle pulse: `ic_ins` valid
- `ic_ins`  out  32  fetched word
- `lsb_asked`  in  1  one-cycle load/store request pulse
- `lsb_wr`  in  1  1 = store
- `lsb_addr`  in  32  byte address
- `lsb_size`  in  2  0 = byte, 1 = half, 2 = word (3 is illegal and treated as word)
- `lsb_wdata`  in  32  store data; low N bytes are used
- `lsb_enable`  out  1  controller can accept an LSB request
- `lsb_rdy`  out  1  one-cycle pulse: load data returned or store done
- `lsb_rdata`  out  32  load data, zero-extended raw bytes

## Operation
- **Reset values:** `ic_enable` = `lsb_enable` = 1. `mem_wr`, `ic_ins_rdy`, `lsb_rdy` = 0. `mem_a`, `mem_dout`, `ic_ins`, `lsb_rdata` = 0. Pending flags are cleared and the state is IDLE.
- **Request capture:**
  - Requests are one-cycle pulses. Each requester has a one-entry pending register that latches addr, size and data on its `*_asked`.
  - `ic_enable` is low while the fetch is pending or in service. `lsb_enable` follows the same rule for the LSB.
  - A requester asserts `*_asked` only after sampling its enable high.
- **Arbitration:** performed in IDLE. The LSB pending request wins over the fetch. A request captured on the same edge as arbitration is eligible immediately. The losing request stays pending.
- **States:**
  - IDLE → READ (fetch, or load) or WRITE (store).
  - WRITE → WAIT_IO when the store is to IO (addr[17:16] = `IO_BASE_HI`) and `io_buffer_full` = 1 at the edge where a byte would be issued.
  - WAIT_IO → WRITE on the first edge where `io_buffer_full` = 0.
  - READ / WRITE → DONE after the last byte.
  - DONE → IDLE. DONE pulses rdy and raises the served requester's enable.
- **Byte count:** N = 4 for a fetch. For the LSB, N = 1, 2 or 4 per `lsb_size`. Byte k uses address addr+k (32-bit add, wraps at 2^32).
- **Data assembly:** byte k of read data goes to bits [8k+7:8k]; unused upper bytes are 0. Store byte k = `lsb_wdata`[8k+7:8k].
- **Bus idle:** outside WRITE, `mem_wr` = 0. `mem_a` holds its last value.
- **Reset mid-transfer:** the access is aborted, `mem_wr` drops to 0 at the reset edge, and no rdy pulse is issued.

## Timing
- **Acceptance:** E0 = the edge at which arbitration selects the request.
- **Read:**
  - Address addr+k is driven in the cycle after edge E_k, for k = 0..N−1.
  - Byte k is sampled from `mem_din` at E_{k+2}.
  - The rdy pulse is high for the cycle after E_{N+2}: a fetch accepted at E0 returns `ic_ins_rdy` = 1 in cycle 6.
  - Fetch latency from `ic_ins_asked` (controller IDLE, no LSB pending) is 7 cycles.
- **Write:**
  - `mem_wr` = 1 with addr+k and byte k driven in the cycle after E_k.
  - `mem_wr` returns to 0 at E_N, and `lsb_rdy` pulses in the cycle after E_N.
  - Each WAIT_IO cycle delays subsequent bytes by one.
- **Enables:** an enable rises in the same cycle as its rdy pulse. A new request may be sampled on the edge ending that cycle.
- **Freeze:** `rdy` = 0 freezes counters, pending registers, `mem_a`/`mem_wr` and the rdy pulses (a pulse held high stays high).
- **Throughput:** back-to-back requests take at least N+3 cycles each (one IDLE cycle between transfers).

## Test plan
- **Fetch:** RAM[0x100..0x103] = 13,05,00,00; pulse `ic_ins_asked` with addr 0x100. Expect `ic_ins` = 0x00000513, `ic_ins_rdy` high exactly one cycle, 7 cycles after the request, and `ic_enable` low in between.
- **Simultaneous requests:** pulse `lsb_asked` (load word 0x200) and `ic_ins_asked` (0x104) on the same edge. Expect the LSB served first, then the fetch with no lost request and no overlap of `mem_a` sequences.
- **Store half:** `lsb_wdata` = 0xAABBCCDD to 0x301. Expect writes 0xDD@0x301 then 0xCC@0x302, 0x302 unchanged in upper bytes, `lsb_rdy` one cycle, no write to 0x303.
- **IO stall:** byte store to 0x30000 while `io_buffer_full` = 1 for 5 cycles. Expect `mem_wr` = 0 throughout the stall, then one write of the byte and `lsb_rdy` after the release.
- **Reset mid-read:** assert `rst` during byte 2 of a fetch. Expect `mem_wr` = 0, no `ic_ins_rdy`, both enables = 1 after reset, and a subsequent fetch correct.
- **Freeze:** hold `rdy` = 0 for 3 cycles mid-load byte read at 0x7. Expect `mem_a` frozen, correct `lsb_rdata` = 0x000000XX, and latency extended by exactly 3 cycles.

Source files
------------

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - arbiter between i-cache fetches, LSB loads/stores and the byte-wide RAM/IO bus
// Serialises each request into 1-4 byte accesses; LSB wins arbitration, IO stores stall on a full IO buffer.
module memory_controller #(
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        ic_ins_asked,
    input  logic [31:0] ic_ins_addr,
    output logic        ic_enable,
    output logic        ic_ins_rdy,
    output logic [31:0] ic_ins,
    input  logic        lsb_asked,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_enable,
    output logic        lsb_rdy,
    output logic [31:0] lsb_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WAIT_IO, S_DONE} state_t;

    state_t      state_q;
    logic        ic_pend_q, lsb_pend_q, ic_en_q, lsb_en_q, lsb_wr_q;
    logic [31:0] ic_addr_q, lsb_addr_q, lsb_wdata_q;
    logic [1:0]  lsb_size_q;
    logic [31:0] cur_addr_q, cur_wdata_q, data_q;
    logic [2:0]  cur_n_q, step_q;
    logic        cur_ic_q, cur_wr_q;
    logic [31:0] mem_a_q, ic_ins_q, lsb_rdata_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q, ic_ins_rdy_q, lsb_rdy_q;

    logic        lsb_req_d, ic_req_d, lsb_wr_d, new_wr_d, do_write_d, wstall_d, idle_d;
    logic [31:0] lsb_addr_d, lsb_wdata_d, ic_addr_d, new_addr_d, wbase_d, wdata_d;
    logic [1:0]  lsb_size_d, rx_d;
    logic [2:0]  new_n_d, widx_d, wn_d;
    logic [7:0]  wbyte_d;

    // A request pulsed on the arbitration edge is visible here alongside the pending copy.
    always_comb begin
        idle_d      = (state_q == S_IDLE);
        lsb_req_d   = lsb_pend_q | (lsb_asked & lsb_en_q);
        ic_req_d    = ic_pend_q | (ic_ins_asked & ic_en_q);
        lsb_addr_d  = lsb_pend_q ? lsb_addr_q  : lsb_addr;
        lsb_wdata_d = lsb_pend_q ? lsb_wdata_q : lsb_wdata;
        lsb_size_d  = lsb_pend_q ? lsb_size_q  : lsb_size;
        lsb_wr_d    = lsb_pend_q ? lsb_wr_q    : lsb_wr;
        ic_addr_d   = ic_pend_q  ? ic_addr_q   : ic_ins_addr;
        new_addr_d  = lsb_req_d ? lsb_addr_d : ic_addr_d;
        if (!lsb_req_d || lsb_size_d[1]) begin
            new_n_d = 3'd4;
        end else if (lsb_size_d[0]) begin
            new_n_d = 3'd2;
        end else begin
            new_n_d = 3'd1;
        end
        new_wr_d   = lsb_req_d & lsb_wr_d;
        do_write_d = (idle_d & new_wr_d) | (state_q == S_WRITE) | (state_q == S_WAIT_IO);
        wbase_d    = idle_d ? new_addr_d  : cur_addr_q;
        wdata_d    = idle_d ? lsb_wdata_d : cur_wdata_q;
        widx_d     = idle_d ? 3'd0        : step_q;
        wn_d       = idle_d ? new_n_d     : cur_n_q;
        wstall_d   = (wbase_d[17:16] == IO_BASE_HI) && io_buffer_full;
        wbyte_d    = wdata_d[{widx_d[1:0], 3'b000} +: 8];
        rx_d       = step_q[1:0] - 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ic_pend_q    <= 1'b0;
            lsb_pend_q   <= 1'b0;
            ic_en_q      <= 1'b1;
            lsb_en_q     <= 1'b1;
            lsb_wr_q     <= 1'b0;
            ic_addr_q    <= '0;
            lsb_addr_q   <= '0;
            lsb_wdata_q  <= '0;
            lsb_size_q   <= '0;
            cur_addr_q   <= '0;
            cur_wdata_q  <= '0;
            data_q       <= '0;
            cur_n_q      <= '0;
            step_q       <= '0;
            cur_ic_q     <= 1'b0;
            cur_wr_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            ic_ins_rdy_q <= 1'b0;
            lsb_rdy_q    <= 1'b0;
            ic_ins_q     <= '0;
            lsb_rdata_q  <= '0;
        end else if (rdy) begin
            ic_ins_rdy_q <= 1'b0;
            lsb_rdy_q    <= 1'b0;
            if (ic_ins_asked && ic_en_q) begin
                ic_pend_q <= 1'b1;
                ic_addr_q <= ic_ins_addr;
                ic_en_q   <= 1'b0;
            end
            if (lsb_asked && lsb_en_q) begin
                lsb_pend_q  <= 1'b1;
                lsb_addr_q  <= lsb_addr;
                lsb_size_q  <= lsb_size;
                lsb_wr_q    <= lsb_wr;
                lsb_wdata_q <= lsb_wdata;
                lsb_en_q    <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (lsb_req_d || ic_req_d) begin
                        if (lsb_req_d) lsb_pend_q <= 1'b0;
                        else           ic_pend_q  <= 1'b0;
                        cur_addr_q  <= new_addr_d;
                        cur_wdata_q <= lsb_wdata_d;
                        cur_n_q     <= new_n_d;
                        cur_ic_q    <= !lsb_req_d;
                        cur_wr_q    <= new_wr_d;
                        data_q      <= '0;
                        if (!new_wr_d) begin
                            mem_a_q <= new_addr_d;
                            step_q  <= 3'd1;
                            state_q <= S_READ;
                        end
                    end
                end
                // step_q counts edges since acceptance; data lags the address by two edges.
                S_READ: begin
                    if (step_q < cur_n_q) mem_a_q <= cur_addr_q + {29'd0, step_q};
                    if (step_q >= 3'd2) data_q[{rx_d, 3'b000} +: 8] <= mem_din;
                    if (step_q == cur_n_q + 3'd1) state_q <= S_DONE;
                    step_q <= step_q + 3'd1;
                end
                S_DONE: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= S_IDLE;
                    if (cur_ic_q) begin
                        ic_ins_rdy_q <= 1'b1;
                        ic_ins_q     <= data_q;
                        ic_en_q      <= 1'b1;
                    end else begin
                        lsb_rdy_q <= 1'b1;
                        lsb_en_q  <= 1'b1;
                        if (!cur_wr_q) lsb_rdata_q <= data_q;
                    end
                end
                default: ;
            endcase
            // Store byte issue, shared by the accepting edge, WRITE and the release from WAIT_IO.
            if (do_write_d) begin
                if (wstall_d) begin
                    mem_wr_q <= 1'b0;
                    step_q   <= widx_d;
                    state_q  <= S_WAIT_IO;
                end else begin
                    mem_wr_q   <= 1'b1;
                    mem_a_q    <= wbase_d + {29'd0, widx_d};
                    mem_dout_q <= wbyte_d;
                    step_q     <= widx_d + 3'd1;
                    state_q    <= (widx_d + 3'd1 == wn_d) ? S_DONE : S_WRITE;
                end
            end
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q;
    assign ic_enable  = ic_en_q;
    assign lsb_enable = lsb_en_q;
    assign ic_ins_rdy = ic_ins_rdy_q;
    assign ic_ins     = ic_ins_q;
    assign lsb_rdy    = lsb_rdy_q;
    assign lsb_rdata  = lsb_rdata_q;
endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - scoreboard bench for memory_controller with a byte RAM and reference memory
module tb_memory_controller;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full = 1'b0;
    logic        ic_ins_asked = 1'b0, ic_enable, ic_ins_rdy;
    logic [31:0] ic_ins_addr = '0, ic_ins;
    logic        lsb_asked = 1'b0, lsb_wr = 1'b0, lsb_enable, lsb_rdy;
    logic [31:0] lsb_addr = '0, lsb_wdata = '0, lsb_rdata;
    logic [1:0]  lsb_size = '0;

    memory_controller #(.IO_BASE_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .ic_ins_asked(ic_ins_asked), .ic_ins_addr(ic_ins_addr), .ic_enable(ic_enable),
        .ic_ins_rdy(ic_ins_rdy), .ic_ins(ic_ins), .lsb_asked(lsb_asked), .lsb_wr(lsb_wr),
        .lsb_addr(lsb_addr), .lsb_size(lsb_size), .lsb_wdata(lsb_wdata),
        .lsb_enable(lsb_enable), .lsb_rdy(lsb_rdy), .lsb_rdata(lsb_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        st;
        logic [31:0] data;
    } lsb_exp_t;

    logic [7:0]  ram     [0:262143];
    logic [7:0]  ref_mem [0:262143];
    logic [31:0] ic_q[$];
    lsb_exp_t    lsb_q[$];
    logic [39:0] wr_q[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          t_ask_ic, t_ask_lsb, ic_rdy_cyc, lsb_rdy_cyc;
    logic        ic_prev = 1'b0, lsb_prev = 1'b0, io_at_edge = 1'b0, rand_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v, ak;
        v = '0;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            v[8*k +: 8] = ref_mem[ak[17:0]];
        end
        return v;
    endfunction

    // Byte RAM: registered read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din    <= ram[mem_a[17:0]];
        io_at_edge <= io_buffer_full;
        cyc        <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ic_ins_rdy) begin
                ic_rdy_cyc = cyc;
                if (ic_prev) fail("ic_rdy_long_pulse");
                if (ic_q.size() == 0) fail("ic_rdy_unexpected");
                else chk("ic_ins", ic_ins, ic_q.pop_front());
            end
            if (lsb_rdy) begin
                lsb_exp_t e;
                lsb_rdy_cyc = cyc;
                if (lsb_prev) fail("lsb_rdy_long_pulse");
                if (lsb_q.size() == 0) fail("lsb_rdy_unexpected");
                else begin
                    e = lsb_q.pop_front();
                    if (!e.st) chk("lsb_rdata", lsb_rdata, e.data);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) fail("write_unexpected");
                else chk("write_addr_data", {mem_a, mem_dout}, wr_q.pop_front());
                if (mem_a[17:16] == 2'b11) chk("io_write_while_full", io_at_edge, 0);
            end
        end
        ic_prev  = ic_ins_rdy;
        lsb_prev = lsb_rdy;
    end

    task automatic do_fetch(input logic [31:0] addr, input logic push);
        int b = 0;
        @(negedge clk);
        while (!ic_enable && b < 300) begin @(negedge clk); b++; end
        if (b >= 300) fail("ic_enable_timeout");
        ic_ins_asked = 1'b1;
        ic_ins_addr  = addr;
        t_ask_ic     = cyc;
        if (push) ic_q.push_back(ref_read(addr, 4));
        @(negedge clk);
        ic_ins_asked = 1'b0;
    endtask

    task automatic do_lsb(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
        int b = 0;
        int n;
        logic [31:0] ak;
        lsb_exp_t e;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        @(negedge clk);
        while (!lsb_enable && b < 300) begin @(negedge clk); b++; end
        if (b >= 300) fail("lsb_enable_timeout");
        e.st   = wr;
        e.data = wr ? 32'd0 : ref_read(addr, n);
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                ak = addr + k;
                wr_q.push_back({ak, wdata[8*k +: 8]});
                ref_mem[ak[17:0]] = wdata[8*k +: 8];
            end
        end
        lsb_q.push_back(e);
        lsb_asked = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_size = size; lsb_wdata = wdata;
        t_ask_lsb = cyc;
        @(negedge clk);
        lsb_asked = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int b = 0;
        while ((ic_q.size() != 0 || lsb_q.size() != 0 || !ic_enable || !lsb_enable) && b < max) begin
            @(negedge clk);
            b++;
        end
        if (b >= max) fail("wait_idle_timeout");
    endtask

    initial begin
        int mism;
        logic [31:0] held;
        for (int i = 0; i < 262144; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        for (int i = 32'h100; i < 32'h104; i++) ref_mem[i] = ram[i];

        repeat (3) @(negedge clk);
        chk("rst_ic_enable", ic_enable, 1);
        chk("rst_lsb_enable", lsb_enable, 1);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_pulses", {ic_ins_rdy, lsb_rdy}, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_data_outs", {mem_dout, ic_ins, lsb_rdata}, 0);
        rst = 1'b0;

        do_fetch(32'h100, 1'b1);
        chk("fetch_ic_enable_low", ic_enable, 0);
        wait_idle(50);
        chk("fetch_word", ic_ins, 32'h0000_0513);
        chk("fetch_latency", ic_rdy_cyc - t_ask_ic, 7);

        fork
            do_lsb(1'b0, 32'h200, 2'd2, 32'd0);
            do_fetch(32'h104, 1'b1);
        join
        wait_idle(80);
        chk("simul_lsb_latency", lsb_rdy_cyc - t_ask_lsb, 7);
        chk("simul_ic_after_lsb", ic_rdy_cyc - lsb_rdy_cyc, 7);

        do_lsb(1'b1, 32'h301, 2'd1, 32'hAABB_CCDD);
        wait_idle(50);
        chk("store_half_0x302", ram[32'h302], 8'hCC);
        chk("store_half_0x303_kept", ram[32'h303], ref_mem[32'h303]);

        io_buffer_full = 1'b1;
        do_lsb(1'b1, 32'h30000, 2'd0, 32'h0000_005A);
        for (int i = 0; i < 5; i++) begin
            chk("io_stall_mem_wr", mem_wr, 0);
            if (i < 4) @(negedge clk);
        end
        io_buffer_full = 1'b0;
        wait_idle(50);
        chk("io_store_byte", ram[32'h30000], 8'h5A);

        do_fetch(32'h40, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_wr", mem_wr, 0);
        chk("midrst_enables", {ic_enable, lsb_enable}, 2'b11);
        chk("midrst_no_rdy", ic_ins_rdy, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        do_fetch(32'h44, 1'b1);
        wait_idle(50);
        chk("postrst_fetch_latency", ic_rdy_cyc - t_ask_ic, 7);

        do_lsb(1'b0, 32'h7, 2'd0, 32'd0);
        @(negedge clk);
        held = mem_a;
        chk("freeze_mem_a_addr", held, 32'h7);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("freeze_mem_a_held", mem_a, held);
        end
        rdy = 1'b1;
        wait_idle(50);
        chk("freeze_latency", lsb_rdy_cyc - t_ask_lsb, 7);
        chk("freeze_rdata_byte", lsb_rdata, {24'd0, ref_mem[7]});

        do_lsb(1'b0, 32'hFFFF_FFFE, 2'd2, 32'd0);
        wait_idle(50);

        fork
            begin
                fork
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        do_fetch(($urandom % 1024) * 4, 1'b1);
                    end
                    for (int j = 0; j < 30; j++) begin
                        int op;
                        op = $urandom % 4;
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        if (op == 3)
                            do_lsb(1'b1, 32'h30000 + ($urandom % 256), 2'($urandom), $urandom);
                        else
                            do_lsb(op == 2, 32'h1000 + ($urandom % 256), 2'($urandom), $urandom);
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    io_buffer_full = ($urandom % 3 == 0);
                end
                io_buffer_full = 1'b0;
            end
        join
        wait_idle(300);
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[32'h1000 + i] !== ref_mem[32'h1000 + i]) mism++;
            if (ram[32'h30000 + i] !== ref_mem[32'h30000 + i]) mism++;
        end
        chk("ram_regions_match_model", mism, 0);
        chk("writes_all_seen", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
